// File: rtl/definitions_pkg.sv
// Shared types and constants for the UART transceiver and its receive core.
package definitions_pkg;

    localparam int UART_DEFAULT_CLKS_PER_BIT = 32;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_mode_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// UART receive core: line synchroniser, mid-bit sampling FSM and frame checks.
//
// state     | meaning
// RX_IDLE   | line high, waiting for a falling edge
// RX_START  | half a bit into the start bit, then confirming it is still low
// RX_DATA   | sampling data bits, LSB first
// RX_PARITY | sampling the parity bit
// RX_STOP   | sampling stop bit(s); the final sample completes the frame
// RX_BREAK  | a stop bit was low; wait for the line to return high
module uart_rx_core
    import definitions_pkg::*;
#(
    parameter int           DATA_BITS    = 8,
    parameter int           CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter parity_mode_e PARITY_MODE  = PAR_NONE,
    parameter int           STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic                 frame_done,
    output logic [DATA_BITS-1:0] frame_data,
    output logic                 frame_perr,
    output logic                 frame_ferr
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

    logic [1:0]           sync_q;
    logic                 rx_s;
    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic                 ferr_q, ferr_d;
    logic                 par_exp;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 2'b11;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            ferr_q  <= ferr_d;
        end
    end

    // Odd parity inverts the data XOR.
    assign par_exp    = (^shreg_q) ^ (PARITY_MODE == PAR_ODD);
    assign frame_data = shreg_q;
    assign frame_perr = (PARITY_MODE != PAR_NONE) && (par_q != par_exp);
    assign frame_ferr = ferr_q | ~rx_s;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        ferr_d     = ferr_q;
        frame_done = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    state_d = RX_START;
                    cnt_d   = CNT_HALF;
                    ferr_d  = 1'b0;
                end
            end
            RX_START: begin
                if (cnt_q == '0) begin
                    if (rx_s) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d = RX_DATA;
                        cnt_d   = CNT_FULL;
                        bit_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == '0) begin
                    shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                    cnt_d   = CNT_FULL;
                    if (bit_q == LAST_DATA) begin
                        bit_d   = '0;
                        state_d = (PARITY_MODE == PAR_NONE) ? RX_STOP : RX_PARITY;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RX_PARITY: begin
                if (cnt_q == '0) begin
                    par_d   = rx_s;
                    cnt_d   = CNT_FULL;
                    bit_d   = '0;
                    state_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == '0) begin
                    ferr_d = ferr_q | ~rx_s;
                    cnt_d  = CNT_FULL;
                    if (bit_q == LAST_STOP) begin
                        frame_done = 1'b1;
                        state_d    = (ferr_q | ~rx_s) ? RX_BREAK : RX_IDLE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RX_BREAK: begin
                if (rx_s) begin
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_transceiver.sv
// UART transceiver: transmit FSM, receive core instance and receive holding register.
//
// state     | meaning
// TX_IDLE   | line high, tx_ready asserted
// TX_START  | driving the start bit
// TX_DATA   | shifting data bits out, LSB first
// TX_PARITY | driving the parity bit
// TX_STOP   | driving stop bit(s)
module uart_transceiver
    import definitions_pkg::*;
#(
    parameter int           DATA_BITS    = 8,
    parameter int           CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter parity_mode_e PARITY_MODE  = PAR_NONE,
    parameter int           STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 ready_q;

    logic                 frame_done;
    logic [DATA_BITS-1:0] frame_data;
    logic                 frame_perr;
    logic                 frame_ferr;

    // tx is registered from the next-state decode so the line never glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            ready_q <= (state_d == TX_IDLE);
        end
    end

    assign tx_ready = ready_q;
    assign tx       = tx_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        tx_d    = tx_q;
        case (state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (tx_valid && ready_q) begin
                    state_d = TX_START;
                    cnt_d   = CNT_FULL;
                    shreg_d = tx_data;
                    par_d   = (^tx_data) ^ (PARITY_MODE == PAR_ODD);
                    tx_d    = 1'b0;
                end
            end
            TX_START: begin
                if (cnt_q == '0) begin
                    state_d = TX_DATA;
                    cnt_d   = CNT_FULL;
                    bit_d   = '0;
                    tx_d    = shreg_q[0];
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            TX_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = CNT_FULL;
                    if (bit_q == LAST_DATA) begin
                        bit_d = '0;
                        if (PARITY_MODE == PAR_NONE) begin
                            state_d = TX_STOP;
                            tx_d    = 1'b1;
                        end else begin
                            state_d = TX_PARITY;
                            tx_d    = par_q;
                        end
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shreg_d = shreg_q >> 1;
                        tx_d    = shreg_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            TX_PARITY: begin
                if (cnt_q == '0) begin
                    state_d = TX_STOP;
                    cnt_d   = CNT_FULL;
                    bit_d   = '0;
                    tx_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            TX_STOP: begin
                if (cnt_q == '0) begin
                    if (bit_q == LAST_STOP) begin
                        state_d = TX_IDLE;
                        cnt_d   = '0;
                        bit_d   = '0;
                    end else begin
                        cnt_d = CNT_FULL;
                        bit_d = bit_q + 1'b1;
                    end
                    tx_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = TX_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    uart_rx_core #(
        .DATA_BITS   (DATA_BITS),
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .PARITY_MODE (PARITY_MODE),
        .STOP_BITS   (STOP_BITS)
    ) u_rx_core (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .frame_done(frame_done),
        .frame_data(frame_data),
        .frame_perr(frame_perr),
        .frame_ferr(frame_ferr)
    );

    // A consumer handshake in the completion cycle frees the register for the new word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            rx_overrun <= 1'b0;
            if (frame_done && (!rx_valid || rx_ready)) begin
                rx_data       <= frame_data;
                rx_parity_err <= frame_perr;
                rx_frame_err  <= frame_ferr;
                rx_valid      <= 1'b1;
            end else if (frame_done) begin
                rx_overrun <= 1'b1;
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_transceiver.sv
// Randomised self-checking bench for uart_transceiver (8 data bits, even parity, 1 stop bit).
module tb_uart_transceiver;
    import definitions_pkg::*;

    localparam int CPB = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       rx_parity_err;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       loop_en = 1'b0;
    logic       rx_drv = 1'b1;

    int checks = 0;
    int failures = 0;
    int ovr_cnt = 0;
    logic [9:0] rxq[$];

    assign rx = loop_en ? tx : rx_drv;

    always #5 clk = ~clk;

    uart_transceiver #(
        .DATA_BITS   (8),
        .CLKS_PER_BIT(CPB),
        .PARITY_MODE (PAR_EVEN),
        .STOP_BITS   (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx           (tx),
        .rx           (rx),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_parity_err(rx_parity_err),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun)
    );

    always @(posedge clk) begin
        if (!rst && rx_valid && rx_ready)
            rxq.push_back({rx_parity_err, rx_frame_err, rx_data});
        if (rx_overrun)
            ovr_cnt++;
    end

    // Reference frame: start, data LSB first, even parity, stop.
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = d[i];
        f[9]  = ^d;
        f[10] = 1'b1;
        return f;
    endfunction

    // Expected receive result {perr, ferr, data} for a hand-built frame.
    function automatic logic [9:0] model_rx(input logic [7:0] d, input logic pbit, input logic sbit);
        return {pbit != (^d), ~sbit, d};
    endfunction

    task automatic tx_send(input logic [7:0] d, input bit hold);
        int n = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            failures++;
            $display("FAIL tx_send_timeout: tx_ready never rose for data %h", d);
        end
        @(negedge clk);
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic ser_bit(input logic b);
        rx_drv = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_serial(input logic [7:0] d, input logic pbit, input logic sbit);
        ser_bit(1'b0);
        for (int i = 0; i < 8; i++) ser_bit(d[i]);
        ser_bit(pbit);
        ser_bit(sbit);
    endtask

    task automatic wait_rx(input int n, input string name);
        int c = 0;
        while (rxq.size() < n && c < 2000) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (rxq.size() < n) begin
            failures++;
            $display("FAIL %s_timeout: received %0d words, required %0d", name, rxq.size(), n);
        end
    endtask

    task automatic check_word(input string name, input logic [9:0] exp);
        logic [9:0] got;
        checks++;
        if (rxq.size() == 0) begin
            failures++;
            $display("FAIL %s: no word received, required %h", name, exp);
        end else begin
            got = rxq.pop_front();
            if (got !== exp) begin
                failures++;
                $display("FAIL %s: got {perr,ferr,data}=%h required %h", name, got, exp);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx, tx_ready, rx_valid, rx_data, rx_parity_err, rx_frame_err, rx_overrun} !== {1'b1, 1'b0, 1'b0, 8'h00, 3'b000}) begin
            failures++;
            $display("FAIL reset_outputs: tx=%b rdy=%b vld=%b data=%h pe=%b fe=%b ov=%b required 1 0 0 00 0 0 0",
                     tx, tx_ready, rx_valid, rx_data, rx_parity_err, rx_frame_err, rx_overrun);
        end
        rst = 1'b0;
        checks++;
        if (tx_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready_early: tx_ready=%b required 0 before first edge", tx_ready);
        end
        @(negedge clk);
        checks++;
        if (tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready_first_edge: tx_ready=%b required 1", tx_ready);
        end
    endtask

    task automatic test_tx_frame(input logic [7:0] d);
        logic [10:0] f;
        int low = 0;
        int bad = 0;
        f = model_frame(d);
        tx_send(d, 1'b0);
        for (int k = 0; k < 11 * CPB; k++) begin
            if (tx !== f[k / CPB]) bad++;
            if (tx_ready === 1'b0) low++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL tx_bits_%h: %0d cycles had a wrong tx level, required 0", d, bad);
        end
        checks++;
        if (low != 11 * CPB || tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL tx_ready_low_%h: low for %0d cycles, ready now %b, required %0d and 1", d, low, tx_ready, 11 * CPB);
        end
    endtask

    task automatic test_back_to_back;
        int gap = 0;
        rxq.delete();
        loop_en  = 1'b1;
        rx_ready = 1'b1;
        tx_send(8'h3C, 1'b1);
        tx_send(8'hFF, 1'b0);
        // tx_send returns one cycle after acceptance; the start bit must already be on the line
        checks++;
        if (tx !== 1'b0) begin
            failures++;
            $display("FAIL b2b_start_bit: tx=%b required 0 right after second acceptance", tx);
        end
        wait_rx(2, "b2b");
        check_word("b2b_word0", model_rx(8'h3C, ^8'h3C, 1'b1));
        check_word("b2b_word1", model_rx(8'hFF, ^8'hFF, 1'b1));
        gap = 0;
        while (tx_ready !== 1'b1 && gap < 500) begin
            @(negedge clk);
            gap++;
        end
        loop_en = 1'b0;
    endtask

    task automatic test_random_loopback;
        logic [7:0] d;
        loop_en  = 1'b1;
        rx_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rxq.delete();
            d = 8'($urandom);
            tx_send(d, 1'b0);
            wait_rx(1, "random");
            check_word("random_word", model_rx(d, ^d, 1'b1));
        end
        repeat (CPB) @(negedge clk);
        loop_en = 1'b0;
    endtask

    task automatic test_glitch;
        logic [7:0] d;
        rxq.delete();
        rx_ready = 1'b1;
        rx_drv = 1'b0;
        repeat (10) @(negedge clk);
        rx_drv = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        checks++;
        if (rxq.size() != 0 || rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL glitch_reject: %0d words, rx_valid=%b, required 0 and 0", rxq.size(), rx_valid);
        end
        d = 8'($urandom);
        send_serial(d, ^d, 1'b1);
        wait_rx(1, "after_glitch");
        check_word("after_glitch_word", model_rx(d, ^d, 1'b1));
    endtask

    task automatic test_parity_err;
        logic [7:0] d;
        rxq.delete();
        rx_ready = 1'b1;
        send_serial(8'h01, 1'b0, 1'b1);
        wait_rx(1, "parity_err");
        check_word("parity_err_01", model_rx(8'h01, 1'b0, 1'b1));
        d = 8'($urandom);
        send_serial(d, ~(^d), 1'b1);
        wait_rx(1, "parity_err_rand");
        check_word("parity_err_rand", model_rx(d, ~(^d), 1'b1));
    endtask

    task automatic test_frame_err;
        logic [7:0] d = 8'h5A;
        rxq.delete();
        rx_ready = 1'b1;
        send_serial(d, ^d, 1'b0);
        rx_drv = 1'b0;
        repeat (5 * CPB) @(negedge clk);
        rx_drv = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        checks++;
        if (rxq.size() != 1) begin
            failures++;
            $display("FAIL frame_err_count: %0d rx_valid handshakes, required 1", rxq.size());
        end
        check_word("frame_err_word", model_rx(d, ^d, 1'b0));
    endtask

    task automatic test_overrun;
        rxq.delete();
        ovr_cnt  = 0;
        rx_ready = 1'b0;
        send_serial(8'h11, ^8'h11, 1'b1);
        send_serial(8'h22, ^8'h22, 1'b1);
        repeat (CPB) @(negedge clk);
        checks++;
        if (ovr_cnt != 1) begin
            failures++;
            $display("FAIL overrun_pulse: %0d overrun cycles, required 1", ovr_cnt);
        end
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
            failures++;
            $display("FAIL overrun_hold: rx_valid=%b rx_data=%h, required 1 and 11", rx_valid, rx_data);
        end
        rx_ready = 1'b1;
        wait_rx(1, "overrun_drain");
        repeat (CPB) @(negedge clk);
        checks++;
        if (rxq.size() != 1) begin
            failures++;
            $display("FAIL overrun_extra: %0d words queued, required 1", rxq.size());
        end
        check_word("overrun_kept", model_rx(8'h11, ^8'h11, 1'b1));
    endtask

    task automatic test_reset_mid_tx;
        tx_send(8'h00, 1'b0);
        repeat (99) @(negedge clk);
        checks++;
        if (tx !== 1'b0) begin
            failures++;
            $display("FAIL mid_tx_level: tx=%b required 0 at cycle 100 of frame 00", tx);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (tx !== 1'b1 || tx_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_tx: tx=%b tx_ready=%b required 1 and 0", tx, tx_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (tx_ready !== 1'b1 || tx !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_tx_recover: tx_ready=%b tx=%b required 1 and 1", tx_ready, tx);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_tx_frame(8'hA5);
        test_tx_frame(8'($urandom));
        test_back_to_back();
        test_random_loopback();
        test_glitch();
        test_parity_err();
        test_frame_err();
        test_overrun();
        test_reset_mid_tx();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
